// File: rtl/pipe_pkg.sv
// Shared EX/MEM field layout for the pipeline boundary stages.
// Payload and control widths are derived from the individual field widths.
package pipe_pkg;

  localparam int MEM_W  = 4;
  localparam int WB_W   = 2;
  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  // Payload: {PC+4+off, Result, OutB, WrReg}, WrReg in the low bits
  localparam int WRREG_LSB  = 0;
  localparam int OUTB_LSB   = WRREG_LSB + REG_W;
  localparam int RESULT_LSB = OUTB_LSB + WORD_W;
  localparam int PCOFF_LSB  = RESULT_LSB + WORD_W;
  localparam int PIPE_DATA_W = PCOFF_LSB + WORD_W;

  // Control: {MEM[3:0], WB[1:0], IOInst, Halt}
  localparam int HALT_BIT    = 0;
  localparam int IOINST_BIT  = 1;
  localparam int WB_LSB      = 2;
  localparam int MEM_LSB     = WB_LSB + WB_W;
  localparam int PIPE_CTRL_W = MEM_LSB + MEM_W;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus data and control registers,
// with load, control squash and full clear.
module pipe_entry_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic              load,
  input  logic              squash,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so main and skid can exchange contents in the same cycle without races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else begin
      valid <= valid_d;
      if (clear) begin
        data <= '0;
        ctrl <= '0;
      end else begin
        if (load) data <= data_d;
        // Squash wins over load so an entry written during a flush lands as a bubble
        if (squash)    ctrl <= '0;
        else if (load) ctrl <= ctrl_d;
      end
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline boundary register with a 2-entry skid buffer; in_ready
// comes straight from the skid valid flop, so out_ready never reaches upstream.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = PIPE_DATA_W,
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter bit FLUSH_DROP = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic              accept, pop, drop, squash;
  logic              main_load, main_valid_d, skid_load, skid_valid_d;

  assign in_ready = ~skid_valid;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    accept       = in_valid & in_ready;
    pop          = main_valid & out_ready;
    drop         = flush & FLUSH_DROP;
    squash       = flush & ~FLUSH_DROP;
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_data_d  = in_data;
    main_ctrl_d  = in_ctrl;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;

    // Skid always refills main first, keeping strict FIFO order
    if (skid_valid) begin
      main_data_d = skid_data;
      main_ctrl_d = skid_ctrl;
    end

    main_load    = (accept & (~main_valid | pop)) | (pop & skid_valid);
    skid_load    = accept & main_valid & ~pop;
    main_valid_d = skid_valid | accept | (main_valid & ~pop);
    skid_valid_d = (skid_valid & ~pop) | skid_load;

    if (drop) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .valid_d (main_valid_d),
    .load    (main_load),
    .squash  (squash),
    .clear   (drop),
    .data_d  (main_data_d),
    .ctrl_d  (main_ctrl_d),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .valid_d (skid_valid_d),
    .load    (skid_load),
    .squash  (squash),
    .clear   (drop),
    .data_d  (in_data),
    .ctrl_d  (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline boundary register. It generalises the fixed EX/MEM latch into a valid/ready stage with a 2-entry skid buffer, so that backpressure from MEM (cache miss, IO wait) never forms a combinational path back into EX.
- Each entry carries a data field and a control field. Flush squashes only the control field (bubble insertion), or can be configured to drop entries entirely.
- Instanced between EX and MEM first; reusable at ID/EX and MEM/WB.

Parameters:
- DATA_W, 101, payload width (PC+4+off, Result, OutB, WrReg concatenated).
- CTRL_W, 8, control width (MEM[3:0], WB[1:0], IOInst, Halt); this field is zeroed on flush.
- FLUSH_DROP, 0, flush mode. 0 = keep entries valid with control zeroed (bubble). 1 = invalidate entries.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; driven from a register only
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- flush  in  1  synchronous squash request (exception or branch)
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_ctrl  out  CTRL_W  head control
- occupancy  out  2  entries held (0..2)

Behaviour:
- Storage is main (drives outputs) and skid (overflow). Each has its own valid, data and ctrl registers.
- State is encoded by the valids: EMPTY (0,0), ONE (1,0), FULL (1,1). The state (0,1) is illegal and must never occur.
- Reset (asynchronous): all valids=0, all data=0, all ctrl=0, so out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=1 after reset.
- If reset asserts mid-transfer, in-flight entries are lost. Upstream must hold in_valid=0 while reset=1.
- Accept occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = !skid_valid, taken from a register, with zero combinational path from out_ready.
- Latency is 1 cycle: an entry accepted in EMPTY appears on out_* on the next cycle.
- Transitions without flush:
  - EMPTY + accept -> ONE (main<=in).
  - ONE + accept + pop -> ONE (main<=in).
  - ONE + accept, no pop -> FULL (skid<=in).
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE (main<=skid). No accept is possible in FULL.
  - Any state with neither accept nor pop holds, with out_* stable. Downstream may rely on stable data while out_valid & !out_ready.
- Ordering: strict FIFO. Skid is never bypassed by a newer entry.
- Flush (sampled at clk edge), FLUSH_DROP=0:
  - Data movement is exactly as without flush.
  - The ctrl of every entry resident after the edge, including one accepted that cycle, is 0.
  - Valids and data are unaffected.
- Flush, FLUSH_DROP=1:
  - After the edge all valids=0 (EMPTY) and the accept that cycle is discarded.
  - data and ctrl registers are don't-care but must be zeroed.
- Flush combined with pop in the same cycle: the pop completes with the pre-flush out_ctrl, because the consumer sampled it. Flush affects only what remains.
- occupancy = main_valid + skid_valid.
- No arithmetic beyond the 2-bit occupancy sum.

Decomposition:
- Shared package pipe_pkg holds:
  - the EX/MEM field widths and offsets (MEM_W=4, WB_W=2, REG_W=5, WORD_W=32);
  - the default DATA_W and CTRL_W, derived from those;
  - localparams for the ctrl bit positions of IOInst and Halt.
- One natural sub-module, pipe_entry_reg: one valid+data+ctrl register with load and squash controls, instanced twice (main, skid).
- The top level holds the valid state logic and the muxing.

Test Plan:
- Reset: assert reset mid-cycle with in_valid=0 -> out_valid, out_ctrl, out_data and occupancy are 0 immediately, without waiting for a clk edge. in_ready=1 after release.
- Streaming: out_ready=1, push data 0x1..0x8 with ctrl 0xA5 each cycle -> each appears 1 cycle later in order, occupancy stays 1, in_ready never drops.
- Backpressure: push 0x10 then 0x11 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x10 held stable. Raise out_ready -> 0x10 then 0x11 pop, and in_ready returns to 1 in the cycle after the first pop.
- Bubble flush (FLUSH_DROP=0): FULL with ctrl 0xFF/0xFF, pulse flush -> both entries remain, out_ctrl=0, out_data unchanged, occupancy=2. The same cycle's in_ctrl is also zeroed on a subsequent accept.
- Drop flush (FLUSH_DROP=1): FULL, flush while in_valid=1 -> next cycle occupancy=0, out_valid=0, and the input entry never appears.
- Flush with simultaneous pop: ONE with ctrl 0x3C, out_ready=1, flush=1, in_valid=1 with ctrl 0x81 -> 0x3C consumed intact, the new head has ctrl 0.
